mac_array_tile: RTL and testbench

Parametrised multi-lane multiply-accumulate tile that replaces the single-MAC datapath of the convolution chip. LANES output channels are computed in parallel: each accepted operand beat carries one shared activation and LANES weights. After a programmed number of beats, each lane's sum is combined with an optional partial sum from external memory, then scaled, narrowed and streamed out one lane at a time. It sits between the on-chip input/kernel memories (operand side) and the external-memory write port / chip output (result side).

---
 rtl/mac_array_pkg.sv | 33 +++
 rtl/mac_lane.sv | 45 ++++
 rtl/mac_array_tile.sv | 160 ++++++++++++++++
 tb/tb_mac_array_tile.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_array_pkg.sv
// Shared types and helpers for the multi-lane MAC tile: FSM state encoding,
// width helpers and the result narrowing/saturation function.
package mac_array_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int len_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    // Clamps to the signed range of ow bits when sat is set; the caller keeps
    // the low ow bits, so the unsaturated path wraps.
    function automatic logic signed [63:0] narrow(input logic signed [63:0] v,
                                                  input int ow, input bit sat);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (ow - 1));
        if (sat && (v > hi)) return hi;
        if (sat && (v < lo)) return lo;
        return v;
    endfunction

endpackage

// File: rtl/mac_lane.sv
// One MAC lane: registered operand pair, signed multiplier and a wrapping
// accumulator that adds the product registered on the previous beat.
module mac_lane
    import mac_array_pkg::*;
#(
    parameter int IO_W  = 16,
    parameter int ACC_W = 32
) (
    input  logic                    clk,
    input  logic                    arst_n_in,
    input  logic                    load_i,
    input  logic                    clear_i,
    input  logic                    acc_en_i,
    input  logic signed [IO_W-1:0]  a_i,
    input  logic signed [IO_W-1:0]  b_i,
    output logic signed [ACC_W-1:0] acc_o
);

    logic signed [IO_W-1:0]   a_q;
    logic signed [IO_W-1:0]   b_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [2*IO_W-1:0] prod;

    assign prod  = a_q * b_q;
    assign acc_o = acc_q;

    always_ff @(posedge clk) begin
        if (!arst_n_in) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else begin
            if (load_i) begin
                a_q <= a_i;
                b_q <= b_i;
            end
            if (clear_i) begin
                acc_q <= '0;
            end else if (acc_en_i) begin
                acc_q <= acc_q + ACC_W'(prod);
            end
        end
    end

endmodule

// File: rtl/mac_array_tile.sv
// LANES-wide MAC tile: shared activation, per-lane weights, optional partial-sum
// add, then scaled/narrowed results streamed per lane. MAC_ARRAY_TILE_SATURATE_EN
// selects clamping instead of wrapping on the final narrowing.
module mac_array_tile
    import mac_array_pkg::*;
#(
    parameter int IO_DATA_WIDTH      = 16,
    parameter int ACCUMULATION_WIDTH = 32,
    parameter int OUTPUT_WIDTH       = 16,
    parameter int OUTPUT_SCALE       = 0,
    parameter int LANES              = 4,
    parameter int MAX_LEN            = 576,
    parameter int LEN_WIDTH          = len_width(MAX_LEN),
    parameter int LANE_W             = idx_width(LANES)
) (
    input  logic                             clk,
    input  logic                             arst_n_in,
    input  logic                             start,
    input  logic [LEN_WIDTH-1:0]             cfg_len,
    input  logic                             cfg_acc_with_0,
    output logic                             running,
    output logic                             done,
    input  logic                             op_valid,
    output logic                             op_ready,
    input  logic [IO_DATA_WIDTH-1:0]         op_a,
    input  logic [LANES*IO_DATA_WIDTH-1:0]   op_b,
    input  logic                             psum_valid,
    output logic                             psum_ready,
    input  logic [ACCUMULATION_WIDTH-1:0]    psum_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [OUTPUT_WIDTH-1:0]          out_data,
    output logic [LANE_W-1:0]                out_lane,
    output state_e                           dbg_state
);

    localparam int CNT_W = $clog2(LANES + 1);
`ifdef MAC_ARRAY_TILE_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    state_e                  state_q, state_d;
    logic [LEN_WIDTH-1:0]    len_q, cnt_q, cnt_d;
    logic                    acc0_q, vld_q;
    logic [CNT_W-1:0]        loaded_q, loaded_d;
    logic                    out_valid_q, out_valid_d;
    logic [OUTPUT_WIDTH-1:0] out_data_q, out_data_d;
    logic [LANE_W-1:0]       out_lane_q, out_lane_d;
    logic                    done_q, done_d;
    logic                    clear, op_fire, out_fire, form_ok, form;
    logic [LANE_W-1:0]       lane_sel;
    logic signed [ACCUMULATION_WIDTH-1:0] acc_w [LANES];
    logic signed [ACCUMULATION_WIDTH-1:0] psum_term, sum, scaled;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        mac_lane #(.IO_W(IO_DATA_WIDTH), .ACC_W(ACCUMULATION_WIDTH)) u_lane (
            .clk      (clk),
            .arst_n_in(arst_n_in),
            .load_i   (op_fire),
            .clear_i  (clear),
            .acc_en_i (vld_q),
            .a_i      (op_a),
            .b_i      (op_b[g*IO_DATA_WIDTH +: IO_DATA_WIDTH]),
            .acc_o    (acc_w[g])
        );
    end

    // A lane result may form only while the output slot is free or emptying.
    assign op_fire    = op_valid && (state_q == RUN);
    assign out_fire   = out_valid_q && out_ready;
    assign form_ok    = (state_q == DRAIN) && (loaded_q < CNT_W'(LANES))
                        && (!out_valid_q || out_ready);
    assign form       = form_ok && (acc0_q || psum_valid);
    assign lane_sel   = LANE_W'(loaded_q);
    assign psum_term  = acc0_q ? '0 : $signed(psum_data);
    assign sum        = acc_w[lane_sel] + psum_term;
    assign scaled     = sum >>> OUTPUT_SCALE;

    assign running    = (state_q != IDLE);
    assign op_ready   = (state_q == RUN);
    assign psum_ready = form_ok && !acc0_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_lane   = out_lane_q;
    assign done       = done_q;
    assign dbg_state  = state_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        loaded_d    = loaded_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_lane_d  = out_lane_q;
        done_d      = 1'b0;
        clear       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    clear    = 1'b1;
                    cnt_d    = '0;
                    loaded_d = '0;
                    state_d  = (cfg_len == '0) ? DRAIN : RUN;
                end
            end
            RUN: begin
                if (op_fire) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == len_q) state_d = FLUSH;
                end
            end
            FLUSH: state_d = DRAIN;
            DRAIN: begin
                if (out_fire) out_valid_d = 1'b0;
                if (form) begin
                    out_valid_d = 1'b1;
                    out_data_d  = OUTPUT_WIDTH'(narrow(64'(scaled), OUTPUT_WIDTH, SAT));
                    out_lane_d  = lane_sel;
                    loaded_d    = loaded_q + 1'b1;
                end
                if (out_fire && (loaded_q == CNT_W'(LANES))) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!arst_n_in) begin
            state_q     <= IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            acc0_q      <= 1'b0;
            vld_q       <= 1'b0;
            loaded_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_lane_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            vld_q       <= op_fire;
            loaded_q    <= loaded_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_lane_q  <= out_lane_d;
            done_q      <= done_d;
            if ((state_q == IDLE) && start) begin
                len_q  <= cfg_len;
                acc0_q <= cfg_acc_with_0;
            end
        end
    end

endmodule

// File: tb/tb_mac_array_tile.sv
// Directed bench for mac_array_tile: arithmetic model of each pass, a per-cycle
// output checker against an expected queue, and literal results per pass.
module tb_mac_array_tile;
    import mac_array_pkg::*;

    localparam int IOW = 16, ACCW = 32, OW = 16, SCALE = 0, LANES = 4;
    localparam int LENW = 10, LW = 2, EW = LW + OW;

    logic                  clk = 1'b0;
    logic                  arst_n_in, start, cfg_acc_with_0;
    logic [LENW-1:0]       cfg_len;
    logic                  running, done, op_valid, op_ready;
    logic [IOW-1:0]        op_a;
    logic [LANES*IOW-1:0]  op_b;
    logic                  psum_valid, psum_ready;
    logic [ACCW-1:0]       psum_data;
    logic                  out_valid, out_ready;
    logic [OW-1:0]         out_data;
    logic [LW-1:0]         out_lane;
    state_e                dbg_state;

    mac_array_tile dut (
        .clk(clk), .arst_n_in(arst_n_in), .start(start), .cfg_len(cfg_len),
        .cfg_acc_with_0(cfg_acc_with_0), .running(running), .done(done),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .psum_valid(psum_valid), .psum_ready(psum_ready), .psum_data(psum_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_lane(out_lane), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0;
    int done_cnt = 0, stall_samples = 0;
    bit op_ready_seen = 0, prev_stall = 0, prev_done = 0;
    logic [EW-1:0] prev_word;
    logic [EW-1:0] exp_q[$];
    logic signed [OW-1:0] got_q[$];
    logic signed [IOW-1:0]  va[16];
    logic signed [IOW-1:0]  vb[16][LANES];
    logic signed [ACCW-1:0] vp[LANES];

    task automatic check(input bit ok, input string name, input longint act, input longint req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Spec-level model: sum of a*b over beats, wrap to 32 bits, add psum, scale, narrow.
    function automatic logic [EW-1:0] model_word(input int lane, input int len, input bit acc0);
        longint s = 0;
        int s32, r;
        for (int b = 0; b < len; b++) s += longint'(va[b]) * longint'(vb[b][lane]);
        s32 = int'(s);
        if (!acc0) s32 = s32 + int'(vp[lane]);
        s32 = s32 >>> SCALE;
`ifdef MAC_ARRAY_TILE_SATURATE_EN
        r = (s32 > 32767) ? 32767 : ((s32 < -32768) ? -32768 : s32);
`else
        r = s32;
`endif
        return {LW'(lane), OW'(r)};
    endfunction

    always @(negedge clk) begin
        #2;
        if (op_ready) op_ready_seen = 1;
        if (done) begin
            done_cnt++;
            check(!running && !prev_done, "done_pulse", {running, prev_done}, 0);
        end
        prev_done = done;
        if (prev_stall)
            check(out_valid && ({out_lane, out_data} == prev_word), "stall_hold",
                  {out_lane, out_data}, prev_word);
        if (out_valid && !out_ready) begin
            stall_samples++;
            check(!psum_ready, "psum_ready_stall", psum_ready, 0);
            prev_stall = 1;
            prev_word  = {out_lane, out_data};
        end else begin
            prev_stall = 0;
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check(0, "unexpected_out", {out_lane, out_data}, 0);
            end else begin
                logic [EW-1:0] w;
                w = exp_q.pop_front();
                check({out_lane, out_data} == w, "out_word", {out_lane, out_data}, w);
            end
            got_q.push_back($signed(out_data));
        end
    end

    task automatic drive_ops(input int len, input bit gaps, input bit hold);
        int beat = 0, guard = 0;
        if (hold) return;
        while (beat < len && guard < 500) begin
            @(negedge clk);
            guard++;
            if (gaps && $urandom_range(0, 2) == 0) begin
                op_valid = 0;
            end else begin
                op_valid = 1;
                op_a = va[beat];
                for (int l = 0; l < LANES; l++) op_b[l*IOW +: IOW] = vb[beat][l];
                #1;
                if (op_ready) beat++;
            end
        end
        if (beat < len) check(0, "op_timeout", beat, len);
        @(negedge clk);
        op_valid = 0;
    endtask

    task automatic drive_psum(input bit acc0);
        int idx = 0, guard = 0;
        if (!acc0) begin
            while (idx < LANES && guard < 500) begin
                @(negedge clk);
                guard++;
                psum_valid = 1;
                psum_data  = vp[idx];
                #1;
                if (psum_ready) idx++;
            end
            if (idx < LANES) check(0, "psum_timeout", idx, LANES);
        end
        @(negedge clk);
        psum_valid = 0;
    endtask

    task automatic drive_ready(input int stall_lane);
        int stalls = 0, guard = 0, d0;
        d0 = done_cnt;
        while (done_cnt == d0 && guard < 400) begin
            @(negedge clk);
            guard++;
            if (out_valid && int'(out_lane) == stall_lane && stalls < 5) begin
                out_ready = 0;
                stalls++;
                start   = 1;   // must be ignored while running
                cfg_len = '0;
            end else begin
                out_ready = 1;
                start     = 0;
            end
        end
        if (done_cnt == d0) check(0, "done_timeout", guard, 400);
        out_ready = 1;
        start     = 0;
    endtask

    task automatic run_pass(input int len, input bit acc0, input bit gaps,
                            input int stall_lane, input bit hold);
        for (int l = 0; l < LANES; l++) exp_q.push_back(model_word(l, len, acc0));
        got_q.delete();
        @(negedge clk);
        cfg_len = LENW'(len);
        cfg_acc_with_0 = acc0;
        start = 1;
        @(negedge clk);
        start = 0;
        fork
            drive_ops(len, gaps, hold);
            drive_psum(acc0);
            drive_ready(stall_lane);
        join
        check(exp_q.size() == 0, "exp_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic check_got(input int e0, input int e1, input int e2, input int e3);
        int e[4];
        e = '{e0, e1, e2, e3};
        check(got_q.size() == 4, "got_count", got_q.size(), 4);
        for (int i = 0; i < 4 && i < got_q.size(); i++)
            check(got_q[i] == OW'(e[i]), "literal", got_q[i], e[i]);
    endtask

    initial begin
        arst_n_in = 0; start = 0; cfg_len = '0; cfg_acc_with_0 = 0;
        op_valid = 0; op_a = '0; op_b = '0;
        psum_valid = 0; psum_data = '0; out_ready = 1;
        repeat (3) @(negedge clk);
        #2;
        check(!running && !done && !op_ready && !psum_ready, "reset_ctrl",
              {running, done, op_ready, psum_ready}, 0);
        check(!out_valid && out_data == 0 && out_lane == 0, "reset_out",
              {out_valid, out_lane, out_data}, 0);
        check(dbg_state == IDLE, "reset_state", dbg_state, IDLE);
        @(negedge clk);
        arst_n_in = 1;

        // Pass 1: 3 beats of a=2, weights 1..4, no psum.
        for (int b = 0; b < 3; b++) begin
            va[b] = 2;
            for (int l = 0; l < LANES; l++) vb[b][l] = IOW'(l + 1);
        end
        run_pass(3, 1, 0, -1, 0);
        check_got(6, 12, 18, 24);

        // Pass 2: 2 beats of 1*5, psums added.
        for (int b = 0; b < 2; b++) begin
            va[b] = 1;
            for (int l = 0; l < LANES; l++) vb[b][l] = 5;
        end
        vp = '{100, -20, 0, 7};
        run_pass(2, 0, 0, -1, 0);
        check_got(110, -10, 10, 17);

        // Pass 3: narrowing boundaries at +/-40000.
        va[0] = 200;
        vb[0] = '{200, -200, 1, 0};
        run_pass(1, 1, 0, -1, 0);
`ifdef MAC_ARRAY_TILE_SATURATE_EN
        check_got(32767, -32768, 200, 0);
`else
        check_got(-25536, 25536, 200, 0);
`endif

        // Pass 4: zero-length pass, op_valid held high throughout.
        vp = '{9, 9, 9, 9};
        op_valid = 1;
        op_ready_seen = 0;
        run_pass(0, 0, 0, -1, 1);
        op_valid = 0;
        check(!op_ready_seen, "len0_no_op_ready", op_ready_seen, 0);
        check_got(9, 9, 9, 9);

        // Pass 5: operand gaps, 5-cycle stall on lane 1, start pulsed mid-pass.
        va[0] = 3; va[1] = -1; va[2] = 7; va[3] = 2;
        for (int b = 0; b < 4; b++) vb[b] = '{1, -2, 3, 4};
        vp = '{1, 2, 3, 4};
        stall_samples = 0;
        run_pass(4, 0, 1, 1, 0);
        check(stall_samples == 5, "stall_cycles", stall_samples, 5);
        check_got(12, -20, 36, 48);

        // Pass 6: reset mid-RUN, then a fresh pass.
        @(negedge clk);
        cfg_len = 4; cfg_acc_with_0 = 1; start = 1;
        @(negedge clk);
        start = 0; op_valid = 1; op_a = 100; op_b = {4{16'd100}};
        repeat (2) @(negedge clk);
        #2;
        check(running, "running_before_reset", running, 1);
        arst_n_in = 0;
        op_valid = 0;
        @(negedge clk);
        #2;
        check(!running && !op_ready && !out_valid && !done, "mid_reset",
              {running, op_ready, out_valid, done}, 0);
        arst_n_in = 1;
        for (int b = 0; b < 2; b++) begin
            va[b] = 5;
            vb[b] = '{1, 1, 1, 1};
        end
        run_pass(2, 1, 0, -1, 0);
        check_got(10, 10, 10, 10);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
